alu_exec_unit: RTL and testbench

- Multi-cycle ALU executor. Consumes the 5-bit ALU control code from the ALU control unit, plus operands, and produces the result, flags and exception indications.
- Single-cycle ops complete in 1 cycle. Shifts run iteratively at 1 bit per cycle.
- Sits in the EX stage. Uses a valid/ready handshake on both sides.
- A flush input lets the interrupt logic abort an in-flight op.

---
 rtl/alu_exec_unit_pkg.sv | 52 +++++
 rtl/alu_exec_unit_shift_iter.sv | 74 +++++++
 rtl/alu_exec_unit.sv | 218 +++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_pkg
// Shared definitions for the EX-stage ALU executor:
//   - ALU_* control codes (same encoding as produced by the ALU control unit)
//   - datapath / control-code / shift-amount widths
//   - executor FSM state encoding
//   - is_shift_op(): identifies the ops routed through the iterative shifter
// ---------------------------------------------------------------------------
package alu_exec_unit_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 5;
    localparam int SHAMT_W   = 5;

    localparam logic [4:0] ALU_Add     = 5'd0;
    localparam logic [4:0] ALU_Addu    = 5'd1;
    localparam logic [4:0] ALU_Sub     = 5'd2;
    localparam logic [4:0] ALU_Subu    = 5'd3;
    localparam logic [4:0] ALU_And     = 5'd4;
    localparam logic [4:0] ALU_Or      = 5'd5;
    localparam logic [4:0] ALU_Xor     = 5'd6;
    localparam logic [4:0] ALU_Nor     = 5'd7;
    localparam logic [4:0] ALU_Slt     = 5'd8;
    localparam logic [4:0] ALU_Sltu    = 5'd9;
    localparam logic [4:0] ALU_Lui     = 5'd10;
    localparam logic [4:0] ALU_Le      = 5'd11;
    localparam logic [4:0] ALU_Gt      = 5'd12;
    localparam logic [4:0] ALU_Ge      = 5'd13;
    localparam logic [4:0] ALU_Jr      = 5'd14;
    localparam logic [4:0] ALU_Jalr    = 5'd15;
    localparam logic [4:0] ALU_Sll     = 5'd16;
    localparam logic [4:0] ALU_Srl     = 5'd17;
    localparam logic [4:0] ALU_Sra     = 5'd18;
    localparam logic [4:0] ALU_Invalid = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    // True for the three shift ops that use the iterative shifter.
    function automatic logic is_shift_op(input logic [4:0] op);
        logic r;
        case (op)
            ALU_Sll, ALU_Srl, ALU_Sra: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_exec_unit_shift_iter.sv
// ---------------------------------------------------------------------------
// alu_shift_iter
// Iterative 1-bit-per-cycle shifter used by alu_exec_unit.
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous abort (drops the working value and count)
//   load          capture load_value / load_count / dir / arith
//   dir           0 = shift left, 1 = shift right
//   arith         right shifts replicate the sign bit when set
//   load_value    initial working value
//   load_count    number of 1-bit steps to perform
//   busy          steps still outstanding
//   done          the step performed this cycle is the last one
//   value         working value after this cycle's step
// ---------------------------------------------------------------------------
module alu_shift_iter
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic               dir,
    input  logic               arith,
    input  logic [WIDTH-1:0]   load_value,
    input  logic [SHAMT_W-1:0] load_count,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   value
);

    logic [WIDTH-1:0]   value_r;
    logic [SHAMT_W-1:0] count_r;
    logic               dir_r;
    logic               arith_r;
    logic [WIDTH-1:0]   step_s;

    // One-bit step of the working register in the latched direction.
    always_comb begin
        step_s = value_r;
        if (dir_r) begin
            step_s = {(arith_r & value_r[WIDTH-1]), value_r[WIDTH-1:1]};
        end else begin
            step_s = {value_r[WIDTH-2:0], 1'b0};
        end
    end

    // Working register and step counter.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value_r <= {WIDTH{1'b0}};
            count_r <= {SHAMT_W{1'b0}};
            dir_r   <= 1'b0;
            arith_r <= 1'b0;
        end else if (load) begin
            value_r <= load_value;
            count_r <= load_count;
            dir_r   <= dir;
            arith_r <= arith;
        end else if (count_r != {SHAMT_W{1'b0}}) begin
            value_r <= step_s;
            count_r <= count_r - {{(SHAMT_W-1){1'b0}}, 1'b1};
        end else begin
            value_r <= value_r;
            count_r <= count_r;
        end
    end

    assign busy  = (count_r != {SHAMT_W{1'b0}});
    assign done  = (count_r == {{(SHAMT_W-1){1'b0}}, 1'b1});
    assign value = step_s;

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Multi-cycle EX-stage ALU executor with valid/ready handshakes.
// Single-cycle ops return one cycle after accept; shifts by n>0 step one bit
// per cycle through alu_shift_iter and return n+1 cycles after accept.
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous abort of any in-flight or held op
//   in_valid/ready  input handshake (op, opa, opb, shamt sampled at accept)
//   out_valid/ready output handshake (result and flags held while stalled)
//   result          operation result
//   zero            result == 0
//   ovf_exc         signed overflow on ALU_Add / ALU_Sub
//   ri_exc          ALU_Invalid or unknown control code
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPW-1:0]     op,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf_exc,
    output logic               ri_exc
);

    alu_state_e       state_r;
    alu_state_e       state_nx_s;

    logic             in_ready_s;
    logic             accept_s;
    logic             start_shift_s;
    logic             shift_load_s;
    logic             shift_dir_s;
    logic             shift_arith_s;
    logic             shift_busy_s;
    logic             shift_done_s;
    logic [WIDTH-1:0] shift_val_s;

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ovf_s;
    logic             alu_ri_s;

    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             ovf_r;
    logic             ri_r;
    logic             out_valid_r;

    assign in_ready_s    = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    // A flush cycle never accepts, even if the unit would otherwise be ready.
    assign accept_s      = in_valid && in_ready_s && !flush;
    assign start_shift_s = is_shift_op(op) && (shamt != {SHAMT_W{1'b0}});
    assign shift_load_s  = accept_s && start_shift_s;
    assign sum_s         = opa + opb;
    assign diff_s        = opa - opb;

    // Single-cycle operation results; a zero-distance shift passes opb through.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
        alu_ri_s  = 1'b0;
        case (op)
            ALU_Add: begin
                alu_res_s = sum_s;
                alu_ovf_s = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum_s[WIDTH-1] != opa[WIDTH-1]);
            end
            ALU_Addu: alu_res_s = sum_s;
            ALU_Sub: begin
                alu_res_s = diff_s;
                alu_ovf_s = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff_s[WIDTH-1] != opa[WIDTH-1]);
            end
            ALU_Subu: alu_res_s = diff_s;
            ALU_And:  alu_res_s = opa & opb;
            ALU_Or:   alu_res_s = opa | opb;
            ALU_Xor:  alu_res_s = opa ^ opb;
            ALU_Nor:  alu_res_s = ~(opa | opb);
            ALU_Slt:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
            ALU_Sltu: alu_res_s = {{(WIDTH-1){1'b0}}, (opa < opb)};
            ALU_Lui:  alu_res_s = {opb[15:0], {(WIDTH-16){1'b0}}};
            ALU_Le:   alu_res_s = {{(WIDTH-1){1'b0}}, (opa[WIDTH-1] || (opa == {WIDTH{1'b0}}))};
            ALU_Gt:   alu_res_s = {{(WIDTH-1){1'b0}}, (!opa[WIDTH-1] && (opa != {WIDTH{1'b0}}))};
            ALU_Ge:   alu_res_s = {{(WIDTH-1){1'b0}}, !opa[WIDTH-1]};
            ALU_Jr, ALU_Jalr:          alu_res_s = opa;
            ALU_Sll, ALU_Srl, ALU_Sra: alu_res_s = opb;
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_ri_s  = 1'b1;
            end
        endcase
    end

    // Shift direction and fill mode for the iterative shifter.
    always_comb begin
        shift_dir_s   = 1'b0;
        shift_arith_s = 1'b0;
        if ((op == ALU_Srl) || (op == ALU_Sra)) begin
            shift_dir_s   = 1'b1;
            shift_arith_s = (op == ALU_Sra);
        end else begin
            shift_dir_s   = 1'b0;
            shift_arith_s = 1'b0;
        end
    end

    alu_shift_iter #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .clr        (flush),
        .load       (shift_load_s),
        .dir        (shift_dir_s),
        .arith      (shift_arith_s),
        .load_value (opb),
        .load_count (shamt),
        .busy       (shift_busy_s),
        .done       (shift_done_s),
        .value      (shift_val_s)
    );

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = start_shift_s ? ST_SHIFT : ST_DONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (shift_done_s) begin
                    state_nx_s = ST_DONE;
                end else if (shift_busy_s) begin
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!out_ready) begin
                    state_nx_s = ST_DONE;
                end else if (accept_s) begin
                    state_nx_s = start_shift_s ? ST_SHIFT : ST_DONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
        if (flush) begin
            state_nx_s = ST_IDLE;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Result/flag registers: captured at accept or on the last shift step.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            ri_r        <= 1'b0;
        end else begin
            out_valid_r <= (state_nx_s == ST_DONE);
            if (accept_s && !start_shift_s) begin
                result_r <= alu_res_s;
                zero_r   <= (alu_res_s == {WIDTH{1'b0}});
                ovf_r    <= alu_ovf_s;
                ri_r     <= alu_ri_s;
            end else if ((state_r == ST_SHIFT) && shift_done_s) begin
                result_r <= shift_val_s;
                zero_r   <= (shift_val_s == {WIDTH{1'b0}});
                ovf_r    <= 1'b0;
                ri_r     <= 1'b0;
            end else begin
                result_r <= result_r;
                zero_r   <= zero_r;
                ovf_r    <= ovf_r;
                ri_r     <= ri_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign ovf_exc   = ovf_r;
    assign ri_exc    = ri_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit. Expected results are pushed to a
// scoreboard queue when an op is issued and popped when the DUT presents it.
// Inputs change 1 time unit after the rising edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        ovf_exc;
    logic        ri_exc;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        ri;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] r;
        logic        ov;
        logic        ri;
        int          lat;
    } vec_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   failed    = 0;

    alu_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .opa       (opa),
        .opb       (opb),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf_exc   (ovf_exc),
        .ri_exc    (ri_exc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [31:0] r, input logic ov, input logic ri);
        exp_t e;
        e.res = r;
        e.z   = (r == 32'h0);
        e.ov  = ov;
        e.ri  = ri;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for one edge, optionally recording its expected result;
    // operands are scrambled afterwards so late sampling would show up.
    task automatic start(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input exp_t e, input bit keep);
        op       = o;
        opa      = a;
        opb      = b;
        shamt    = sh;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op       = 5'($urandom);
        opa      = $urandom;
        opb      = $urandom;
        shamt    = 5'($urandom);
        if (keep) sb.push_back(e);
    endtask

    // Bounded wait for out_valid; lat counts edges since accept, stalls counts
    // cycles seen with in_ready low.
    task automatic wait_valid(input int budget, output int lat, output int stalls);
        lat    = 1;
        stalls = 0;
        while (out_valid !== 1'b1 && lat < budget) begin
            if (in_ready === 1'b0) stalls++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 5'd0; opa = 32'h0; opb = 32'h0; shamt = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        tests_run++;
        if ({out_valid, result, zero, ovf_exc, ri_exc} !== 36'h0) begin
            failed++;
            $display("FAIL reset_outputs: got valid=%b res=%h z=%b ov=%b ri=%b, expected all 0",
                     out_valid, result, zero, ovf_exc, ri_exc);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        int lat, st;
        exp_t e, got;
        start(ALU_Add, 32'd5, 32'd7, 5'd0, mk(32'd12, 1'b0, 1'b0), 1'b1);
        wait_valid(10, lat, st);
        got = {result, zero, ovf_exc, ri_exc};
        e = sb.pop_front();
        tests_run++;
        if (lat !== 1 || got !== e) begin
            failed++;
            $display("FAIL basic_add: got res=%h z=%b ov=%b ri=%b lat=%0d, expected res=%h z=%b ov=%b ri=%b lat=1",
                     got.res, got.z, got.ov, got.ri, lat, e.res, e.z, e.ov, e.ri);
        end
        tick();
    endtask

    task automatic test_overflow();
        vec_t v[$];
        int lat, st;
        exp_t e, got;
        v.push_back('{ALU_Add,  32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b1, 1'b0, 1});
        v.push_back('{ALU_Addu, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Sub,  32'h00000009, 32'h00000009, 5'd0, 32'h00000000, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Sub,  32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 1});
        v.push_back('{ALU_Subu, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Add,  32'h80000000, 32'h80000000, 5'd0, 32'h00000000, 1'b1, 1'b0, 1});
        v.push_back('{ALU_Sub,  32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h80000000, 1'b1, 1'b0, 1});
        foreach (v[i]) begin
            start(v[i].op, v[i].a, v[i].b, v[i].sh, mk(v[i].r, v[i].ov, v[i].ri), 1'b1);
            wait_valid(10, lat, st);
            got = {result, zero, ovf_exc, ri_exc};
            e = sb.pop_front();
            tests_run++;
            if (lat !== v[i].lat || got !== e) begin
                failed++;
                $display("FAIL overflow[%0d]: got res=%h z=%b ov=%b ri=%b lat=%0d, expected res=%h z=%b ov=%b ri=%b lat=%0d",
                         i, got.res, got.z, got.ov, got.ri, lat, e.res, e.z, e.ov, e.ri, v[i].lat);
            end
            tick();
        end
    endtask

    task automatic test_shift();
        vec_t v[$];
        int lat, st;
        exp_t e, got;
        v.push_back('{ALU_Sra, 32'h0, 32'h80000010, 5'd4,  32'hF8000001, 1'b0, 1'b0, 5});
        v.push_back('{ALU_Sll, 32'h0, 32'hA5A50001, 5'd0,  32'hA5A50001, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Sll, 32'h0, 32'h00000001, 5'd3,  32'h00000008, 1'b0, 1'b0, 4});
        v.push_back('{ALU_Srl, 32'h0, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0, 32});
        v.push_back('{ALU_Sra, 32'h0, 32'h40000000, 5'd2,  32'h10000000, 1'b0, 1'b0, 3});
        v.push_back('{ALU_Sll, 32'h0, 32'h80000000, 5'd1,  32'h00000000, 1'b0, 1'b0, 2});
        foreach (v[i]) begin
            start(v[i].op, v[i].a, v[i].b, v[i].sh, mk(v[i].r, v[i].ov, v[i].ri), 1'b1);
            wait_valid(40, lat, st);
            got = {result, zero, ovf_exc, ri_exc};
            e = sb.pop_front();
            tests_run++;
            if (lat !== v[i].lat || got !== e) begin
                failed++;
                $display("FAIL shift[%0d]: got res=%h z=%b ov=%b ri=%b lat=%0d, expected res=%h z=%b ov=%b ri=%b lat=%0d",
                         i, got.res, got.z, got.ov, got.ri, lat, e.res, e.z, e.ov, e.ri, v[i].lat);
            end
            tests_run++;
            if (st !== int'(v[i].sh)) begin
                failed++;
                $display("FAIL shift_stall[%0d]: in_ready low for %0d cycles, expected %0d", i, st, v[i].sh);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat, st;
        exp_t e, got;
        out_ready = 1'b0;
        start(ALU_Or, 32'h000000F0, 32'h0000000F, 5'd0, mk(32'h000000FF, 1'b0, 1'b0), 1'b1);
        wait_valid(10, lat, st);
        tests_run++;
        if (lat !== 1) begin
            failed++;
            $display("FAIL bp_latency: got %0d, expected 1", lat);
        end
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (out_valid !== 1'b1 || result !== 32'h000000FF || zero !== 1'b0 || in_ready !== 1'b0) begin
                failed++;
                $display("FAIL bp_hold[%0d]: got valid=%b res=%h z=%b in_ready=%b, expected valid=1 res=000000ff z=0 in_ready=0",
                         c, out_valid, result, zero, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL bp_release_ready: got %b, expected 1", in_ready);
        end
        got = {result, zero, ovf_exc, ri_exc};
        e = sb.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || got !== e) begin
            failed++;
            $display("FAIL bp_or: got valid=%b res=%h z=%b, expected valid=1 res=%h z=%b",
                     out_valid, got.res, got.z, e.res, e.z);
        end
        start(ALU_Slt, 32'hFFFFFFFF, 32'h00000000, 5'd0, mk(32'd1, 1'b0, 1'b0), 1'b1);
        wait_valid(10, lat, st);
        got = {result, zero, ovf_exc, ri_exc};
        e = sb.pop_front();
        tests_run++;
        if (lat !== 1 || got !== e) begin
            failed++;
            $display("FAIL bp_slt_b2b: got res=%h z=%b lat=%0d, expected res=%h z=%b lat=1",
                     got.res, got.z, lat, e.res, e.z);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        int lat, st;
        exp_t e, got;
        v.push_back('{ALU_Add, 32'h00000001, 32'h00000002, 5'd0, 32'h00000003, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Sll, 32'h00000000, 32'h00000003, 5'd2, 32'h0000000C, 1'b0, 1'b0, 3});
        v.push_back('{ALU_Xor, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0, 32'hF0F00F0F, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Invalid, 32'h1, 32'h2, 5'd0, 32'h00000000, 1'b0, 1'b1, 1});
        v.push_back('{ALU_Add, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0, 32'hFFFFFFFE, 1'b1, 1'b0, 1});
        foreach (v[i]) begin
            start(v[i].op, v[i].a, v[i].b, v[i].sh, mk(v[i].r, v[i].ov, v[i].ri), 1'b1);
            wait_valid(40, lat, st);
            got = {result, zero, ovf_exc, ri_exc};
            e = sb.pop_front();
            tests_run++;
            if (lat !== v[i].lat || got !== e) begin
                failed++;
                $display("FAIL b2b[%0d]: got res=%h z=%b ov=%b ri=%b lat=%0d, expected res=%h z=%b ov=%b ri=%b lat=%0d",
                         i, got.res, got.z, got.ov, got.ri, lat, e.res, e.z, e.ov, e.ri, v[i].lat);
            end
        end
        tick();
    endtask

    task automatic test_flush();
        int lat, st, seen;
        exp_t e, got;
        start(ALU_Srl, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, mk(32'h0, 1'b0, 1'b0), 1'b0);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL flush_shift: got valid=%b in_ready=%b, expected valid=0 in_ready=1", out_valid, in_ready);
        end
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        tests_run++;
        if (seen !== 0) begin
            failed++;
            $display("FAIL flush_no_result: out_valid high in %0d cycles, expected 0", seen);
        end
        // An op presented during flush must not be accepted.
        op = ALU_Add; opa = 32'd1; opb = 32'd1; shamt = 5'd0; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL flush_reject: got valid=%b in_ready=%b, expected valid=0 in_ready=1", out_valid, in_ready);
        end
        // Flush discards a result held under backpressure.
        out_ready = 1'b0;
        start(ALU_Add, 32'd2, 32'd3, 5'd0, mk(32'd5, 1'b0, 1'b0), 1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL flush_done: got valid=%b in_ready=%b, expected valid=0 in_ready=1", out_valid, in_ready);
        end
        start(ALU_Lui, 32'h0000DEAD, 32'hFFFF1234, 5'd0, mk(32'h12340000, 1'b0, 1'b0), 1'b1);
        wait_valid(10, lat, st);
        got = {result, zero, ovf_exc, ri_exc};
        e = sb.pop_front();
        tests_run++;
        if (lat !== 1 || got !== e) begin
            failed++;
            $display("FAIL flush_then_lui: got res=%h z=%b lat=%0d, expected res=%h z=%b lat=1",
                     got.res, got.z, lat, e.res, e.z);
        end
        tick();
    endtask

    task automatic test_ops();
        vec_t v[$];
        int lat, st;
        exp_t e, got;
        v.push_back('{ALU_Invalid, 32'h00000001, 32'h00000002, 5'd0, 32'h00000000, 1'b0, 1'b1, 1});
        v.push_back('{5'd20,       32'h00000001, 32'h00000002, 5'd0, 32'h00000000, 1'b0, 1'b1, 1});
        v.push_back('{ALU_Le,   32'h00000000, 32'h00000055, 5'd0, 32'h00000001, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Le,   32'hFFFFFFFB, 32'h00000055, 5'd0, 32'h00000001, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Le,   32'h00000001, 32'h00000055, 5'd0, 32'h00000000, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Gt,   32'hFFFFFFFF, 32'h00000055, 5'd0, 32'h00000000, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Gt,   32'h00000001, 32'h00000055, 5'd0, 32'h00000001, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Gt,   32'h00000000, 32'h00000055, 5'd0, 32'h00000000, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Ge,   32'h00000003, 32'h00000055, 5'd0, 32'h00000001, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Ge,   32'h80000000, 32'h00000055, 5'd0, 32'h00000000, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Ge,   32'h00000000, 32'h00000055, 5'd0, 32'h00000001, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Jr,   32'h00400020, 32'h00000055, 5'd0, 32'h00400020, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Jalr, 32'h00001234, 32'h00000005, 5'd0, 32'h00001234, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Subu, 32'h00000005, 32'h00000007, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0, 1});
        v.push_back('{ALU_And,  32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Nor,  32'h00000000, 32'h00000000, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Nor,  32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0, 32'h00000000, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Or,   32'h00000000, 32'h00000000, 5'd0, 32'h00000000, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Slt,  32'h00000005, 32'hFFFFFFFD, 5'd0, 32'h00000000, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Slt,  32'hFFFFFFFD, 32'h00000005, 5'd0, 32'h00000001, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Sltu, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000001, 1'b0, 1'b0, 1});
        v.push_back('{ALU_Sltu, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b0, 1'b0, 1});
        foreach (v[i]) begin
            start(v[i].op, v[i].a, v[i].b, v[i].sh, mk(v[i].r, v[i].ov, v[i].ri), 1'b1);
            wait_valid(10, lat, st);
            got = {result, zero, ovf_exc, ri_exc};
            e = sb.pop_front();
            tests_run++;
            if (lat !== v[i].lat || got !== e) begin
                failed++;
                $display("FAIL ops[%0d]: got res=%h z=%b ov=%b ri=%b lat=%0d, expected res=%h z=%b ov=%b ri=%b lat=%0d",
                         i, got.res, got.z, got.ov, got.ri, lat, e.res, e.z, e.ov, e.ri, v[i].lat);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_ops();
        tests_run++;
        if (sb.size() !== 0) begin
            failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
